// File: rtl/busca_instrucao_if.sv
// busca_instrucao_if
//   Bundles the instruction-fetch stage's bus signals: the instruction
//   memory request/response and the decode-side head-of-queue outputs.
//   master : the fetch unit (drives imem_req/imem_addr and the id_* outputs)
//   slave  : the surrounding system (memory, branch unit, decode stage)
//   Signals:
//     imem_req, imem_addr[31:0]      fetch request and word-aligned address
//     imem_ready, imem_rdata[31:0]   memory accepts; data valid same cycle
//     branch_taken, branch_target    redirect pulse and target address
//     id_ready                       decode accepts the head instruction
//     id_valid, id_pc, id_instr      head instruction and its PC
//     opcode, funct3, funct7         head instruction fields for control decode
interface busca_instrucao_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  modport master (
    output imem_req, imem_addr, id_valid, id_pc, id_instr, opcode, funct3, funct7,
    input  imem_ready, imem_rdata, branch_taken, branch_target, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_pc, id_instr, opcode, funct3, funct7,
    output imem_ready, imem_rdata, branch_taken, branch_target, id_ready
  );
endinterface

// File: rtl/busca_instrucao.sv
// busca_instrucao
//   Instruction fetch stage. Holds the PC, issues word-aligned requests to
//   instruction memory, and buffers fetched words with their PC in a
//   2-entry FIFO whose head is presented to the decode stage.
//   Ports:
//     clk  - single clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - busca_instrucao_if.master (memory request/response, redirect,
//            decode handshake and head-instruction fields)
//   Configuration:
//     BUSCA_EBREAK_HALT_EN - when defined, fetching the EBREAK word
//     (0x00100073) pushes it normally and then parks the unit in HALT with
//     no further requests until a branch redirect or reset.
module busca_instrucao (
  input logic              clk,
  input logic              rst,
  busca_instrucao_if.master bus
);

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    HALT     = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [1:0]  count;
  logic        wr_ptr, rd_ptr;
  logic        flush, xfer, pop;
  logic        vld_p1;

  logic [31:0] fifo_pc_p1    [2];
  logic [31:0] fifo_instr_p1 [2];
  logic [31:0] head_instr;

  // A redirect in IDLE is ignored; everywhere else it wins over any
  // same-cycle transfer or pop.
  assign flush        = bus.branch_taken && (state != IDLE);
  assign bus.imem_req = (state == RUN) && (count != 2'd2);
  assign xfer         = bus.imem_req && bus.imem_ready && !flush;
  assign pop          = vld_p1 && bus.id_ready && !flush;
  assign bus.imem_addr = pc;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = RUN;
      RUN: begin
`ifdef BUSCA_EBREAK_HALT_EN
        if (xfer && (bus.imem_rdata == EBREAK_WORD)) state_nxt = HALT;
`endif
      end
      REDIRECT: state_nxt = RUN;
`ifdef BUSCA_EBREAK_HALT_EN
      HALT:     state_nxt = HALT;
`endif
      default:  state_nxt = IDLE;
    endcase
    if (flush) state_nxt = REDIRECT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= 32'h0;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        // Clearing the low bits keeps the PC word aligned for any target.
        pc     <= bus.branch_target & 32'hFFFF_FFFC;
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (xfer) pc <= pc + 32'd4;
        if (xfer) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        case ({xfer, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // ---- stage p0 -> p1: fetched word and its PC enter the FIFO ----
  always_ff @(posedge clk) begin
    if (xfer) begin
      fifo_pc_p1[wr_ptr]    <= pc;
      fifo_instr_p1[wr_ptr] <= bus.imem_rdata;
    end
  end

  // ---- stage p1 -> decode: FIFO head, forced to zero when empty ----
  assign vld_p1       = (count != 2'd0);
  assign head_instr   = vld_p1 ? fifo_instr_p1[rd_ptr] : 32'h0;
  assign bus.id_valid = vld_p1;
  assign bus.id_pc    = vld_p1 ? fifo_pc_p1[rd_ptr] : 32'h0;
  assign bus.id_instr = head_instr;
  assign bus.opcode   = head_instr[6:0];
  assign bus.funct3   = head_instr[14:12];
  assign bus.funct7   = head_instr[31:25];

endmodule

// File: tb/tb_busca_instrucao.sv
// tb_busca_instrucao
//   Directed bench for busca_instrucao. Memory returns a fixed word per
//   address; every fetch the bench expects is queued with its PC and word,
//   and each decode-side pop is compared against the queue head.
module tb_busca_instrucao;

  logic clk;
  logic rst;
  busca_instrucao_if bus ();

  busca_instrucao dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)  return 32'h0020_81B3;
    if (a == 32'h10) return 32'h0010_0073;
    return a + 32'h13;
  endfunction

  always_comb bus.imem_rdata = mem_word(bus.imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    check("imem_req", {31'h0, bus.imem_req}, 32'h1);
    check("imem_addr", bus.imem_addr, a);
    sb.push_back({a, mem_word(a)});
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req"},    {31'h0, bus.imem_req}, 32'h0);
    check({tag, "_addr"},   bus.imem_addr, 32'h0);
    check({tag, "_valid"},  {31'h0, bus.id_valid}, 32'h0);
    check({tag, "_pc"},     bus.id_pc, 32'h0);
    check({tag, "_instr"},  bus.id_instr, 32'h0);
    check({tag, "_opcode"}, {25'h0, bus.opcode}, 32'h0);
    check({tag, "_funct3"}, {29'h0, bus.funct3}, 32'h0);
    check({tag, "_funct7"}, {25'h0, bus.funct7}, 32'h0);
  endtask

  // Scoreboard: compare every accepted head instruction.
  exp_t e;
  always @(negedge clk) begin
    if (!rst && bus.id_valid && bus.id_ready && !bus.branch_taken) begin
      n_checks++;
      assert (sb.size() != 0) else begin
        n_errors++;
        $error("FAIL sb_unexpected_pop: observed pc 0x%08h expected none", bus.id_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_pc", bus.id_pc, e.pc);
        check("sb_instr", bus.id_instr, e.instr);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b1;
    bus.imem_ready    = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.id_ready      = 1'b0;

    // Reset state
    at_neg();
    check_zero_outputs("reset");

    // Streaming fetch with both sides ready
    step();
    rst = 1'b0; bus.imem_ready = 1'b1; bus.id_ready = 1'b1;
    at_neg();
    check("idle_req", {31'h0, bus.imem_req}, 32'h0);
    step(); at_neg();
    expect_fetch(32'h0);
    check("first_valid", {31'h0, bus.id_valid}, 32'h0);
    step(); at_neg();
    expect_fetch(32'h4);
    check("head_pc0", bus.id_pc, 32'h0);
    check("opcode", {25'h0, bus.opcode}, 32'h33);
    check("funct3", {29'h0, bus.funct3}, 32'h0);
    check("funct7", {25'h0, bus.funct7}, 32'h0);
    step(); at_neg();
    expect_fetch(32'h8);
    check("head_pc4", bus.id_pc, 32'h4);

    // Decode back-pressure: FIFO fills, requests stop
    step();
    rst = 1'b1; bus.id_ready = 1'b0; bus.imem_ready = 1'b1; sb.delete();
    step();
    rst = 1'b0;
    at_neg();
    check("bp_idle_req", {31'h0, bus.imem_req}, 32'h0);
    step(); at_neg(); expect_fetch(32'h0);
    step(); at_neg(); expect_fetch(32'h4);
    repeat (2) begin
      step(); at_neg();
      check("full_req", {31'h0, bus.imem_req}, 32'h0);
      check("full_addr", bus.imem_addr, 32'h8);
      check("full_head", bus.id_pc, 32'h0);
    end
    step();
    bus.id_ready = 1'b1; bus.imem_ready = 1'b0;
    at_neg(); check("drain_pc0", bus.id_pc, 32'h0);
    step(); at_neg(); check("drain_pc4", bus.id_pc, 32'h4);
    step(); at_neg();
    check("drained_valid", {31'h0, bus.id_valid}, 32'h0);
    check("drained_req", {31'h0, bus.imem_req}, 32'h1);
    check("drained_addr", bus.imem_addr, 32'h8);

    // Memory stall: address held, no push
    step();
    rst = 1'b1; bus.imem_ready = 1'b1; bus.id_ready = 1'b1; sb.delete();
    step();
    rst = 1'b0;
    at_neg(); check("st_idle_req", {31'h0, bus.imem_req}, 32'h0);
    step(); at_neg(); expect_fetch(32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      bus.imem_ready = 1'b0;
      at_neg();
      check("stall_req", {31'h0, bus.imem_req}, 32'h1);
      check("stall_addr", bus.imem_addr, 32'h4);
      if (i > 0) check("stall_valid", {31'h0, bus.id_valid}, 32'h0);
    end
    step();
    bus.imem_ready = 1'b1;
    at_neg();
    expect_fetch(32'h4);
    check("stall_nopush", {31'h0, bus.id_valid}, 32'h0);
    step(); at_neg(); expect_fetch(32'h8);
    step();
    bus.id_ready = 1'b0;
    at_neg();
    expect_fetch(32'hC);
    check("pre_br_head", bus.id_pc, 32'h8);
    step(); at_neg();
    check("pre_br_req", {31'h0, bus.imem_req}, 32'h0);
    check("pre_br_addr", bus.imem_addr, 32'h10);

    // Redirect with FIFO holding 0x8, 0xC to an unaligned target
    step();
    bus.branch_taken = 1'b1; bus.branch_target = 32'h41; sb.delete();
    at_neg(); check("br_head", bus.id_pc, 32'h8);
    step();
    bus.branch_taken = 1'b0;
    at_neg();
    check("redir_valid", {31'h0, bus.id_valid}, 32'h0);
    check("redir_req", {31'h0, bus.imem_req}, 32'h0);
    step(); at_neg();
    check("new_path_valid", {31'h0, bus.id_valid}, 32'h0);
    expect_fetch(32'h40);

    // Asynchronous reset while full and stalled
    step(); at_neg();
    expect_fetch(32'h44);
    check("fill_head", bus.id_pc, 32'h40);
    step();
    bus.imem_ready = 1'b0;
    at_neg();
    check("full2_req", {31'h0, bus.imem_req}, 32'h0);
    check("full2_addr", bus.imem_addr, 32'h48);
    check("full2_valid", {31'h0, bus.id_valid}, 32'h1);
    #2;
    rst = 1'b1; sb.delete();
    #1;
    check_zero_outputs("async_rst");
    step();
    rst = 1'b0; bus.imem_ready = 1'b1; bus.id_ready = 1'b1;
    at_neg();
    check("post_rst_req", {31'h0, bus.imem_req}, 32'h0);
    check("post_rst_addr", bus.imem_addr, 32'h0);

    // EBREAK word at 0x10
    for (int a = 0; a <= 16; a += 4) begin
      step(); at_neg();
      expect_fetch(a);
    end
`ifdef BUSCA_EBREAK_HALT_EN
    for (int i = 0; i < 3; i++) begin
      step(); at_neg();
      check("halt_req", {31'h0, bus.imem_req}, 32'h0);
      if (i == 0) check("halt_head", bus.id_pc, 32'h10);
      else check("halt_drained", {31'h0, bus.id_valid}, 32'h0);
    end
    step();
    bus.branch_taken = 1'b1; bus.branch_target = 32'h100; sb.delete();
    at_neg(); check("halt_br_req", {31'h0, bus.imem_req}, 32'h0);
`else
    step(); at_neg();
    expect_fetch(32'h14);
    check("ebreak_head", bus.id_pc, 32'h10);
    check("ebreak_word", bus.id_instr, 32'h0010_0073);
    step(); at_neg();
    expect_fetch(32'h18);
    step();
    bus.branch_taken = 1'b1; bus.branch_target = 32'h100; sb.delete();
    at_neg();
`endif
    step();
    bus.branch_taken = 1'b0;
    at_neg();
    check("br2_bubble", {31'h0, bus.imem_req}, 32'h0);
    step(); at_neg();
    expect_fetch(32'h100);
    step(); at_neg();
    check("br2_head", bus.id_pc, 32'h100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
